// File: rtl/main_fsm_ctrl.sv
// main_fsm_ctrl: multicycle RV32I-subset control FSM with a memory handshake and a bus-wait timeout.
// Define ILLEGAL_OP_TRAP_EN to send unknown opcodes to HALT; otherwise they retire as NOPs.
module main_fsm_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       halted
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, LUI, HALT
    } state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic timeout, pc_update, branch;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    always_comb begin
        state_nx   = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        halted     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        // a waiting access that has used its whole budget gives up
        timeout    = (WAIT_LIMIT != 0) && (cnt == CNT_W'(WAIT_LIMIT));
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                state_nx   = mem_ready ? DECODE : timeout ? HALT : FETCH;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_nx = MEMADR;
                    7'b0110011:             state_nx = EXECR;
                    7'b0010011:             state_nx = EXECI;
                    7'b1100011:             state_nx = BEQ;
                    7'b1101111:             state_nx = JAL;
                    7'b0110111:             state_nx = LUI;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                state_nx = HALT;
`else
                    default:                state_nx = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nx  = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req  = 1'b1;
                adr_src  = 1'b1;
                state_nx = mem_ready ? MEMWB : timeout ? HALT : MEMREAD;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nx   = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                state_nx  = mem_ready ? FETCH : timeout ? HALT : MEMWRITE;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_nx  = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_nx  = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_nx  = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                state_nx  = FETCH;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_nx  = ALUWB;
            end
            LUI: begin
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_nx   = FETCH;
            end
            HALT: begin
                halted   = 1'b1;
                state_nx = HALT;
            end
            default: state_nx = FETCH;
        endcase
        cnt_nx   = (state_nx == state && !mem_ready && (mem_req || halted))
                   ? ((cnt == '1) ? cnt : cnt + 1'b1) : '0;
        pc_write = pc_update | (branch & zero);
        // outputs are forced quiet for as long as reset is held
        if (!rst_n) begin
            {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, halted} = '0;
            {alu_src_a, alu_src_b, alu_op, result_src} = '0;
        end
    end
endmodule

// File: tb/tb_main_fsm_ctrl.sv
// tb_main_fsm_ctrl: table-driven instruction sequences plus hand-written handshake, timeout and reset cases.
module tb_main_fsm_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, halted;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [14:0] outs;
    int checks = 0;
    int failures = 0;
    logic [14:0] expq[$];

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,alu_op,result_src,halted}
    localparam logic [14:0] V_ZERO   = 15'b000000_00_00_00_00_0;
    localparam logic [14:0] V_FETCH  = 15'b100110_00_10_00_10_0;
    localparam logic [14:0] V_FWAIT  = 15'b100000_00_10_00_10_0;
    localparam logic [14:0] V_DEC    = 15'b000000_01_01_00_00_0;
    localparam logic [14:0] V_MEMADR = 15'b000000_10_01_00_00_0;
    localparam logic [14:0] V_MEMRD  = 15'b101000_00_00_00_00_0;
    localparam logic [14:0] V_MEMWB  = 15'b000001_00_00_00_01_0;
    localparam logic [14:0] V_MEMWR  = 15'b111000_00_00_00_00_0;
    localparam logic [14:0] V_EXR    = 15'b000000_10_00_10_00_0;
    localparam logic [14:0] V_EXI    = 15'b000000_10_01_10_00_0;
    localparam logic [14:0] V_ALUWB  = 15'b000001_00_00_00_00_0;
    localparam logic [14:0] V_BEQ1   = 15'b000010_10_00_01_00_0;
    localparam logic [14:0] V_BEQ0   = 15'b000000_10_00_01_00_0;
    localparam logic [14:0] V_JAL    = 15'b000010_01_10_00_00_0;
    localparam logic [14:0] V_LUI    = 15'b000001_00_00_00_11_0;
    localparam logic [14:0] V_HALT   = 15'b000000_00_00_00_00_1;

    typedef struct {
        logic [6:0]       op;
        logic             z;
        int               n;
        logic [5:0][14:0] seq;
        string            nm;
    } vec_t;
    vec_t tbl[$];

    main_fsm_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .halted(halted)
    );

    assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, alu_op, result_src, halted};

    always #5 clk = ~clk;

    task automatic check(input string nm);
        logic [14:0] e;
        e = expq.pop_front();
        checks++;
        if (outs !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, outs, e);
        end
    endtask

    // called at a negedge: drive, queue the expectation, sample mid-low-phase, move to next negedge
    task automatic step(input logic [6:0] o, input logic z, input logic r, input logic [14:0] e,
                        input string nm);
        op = o; zero = z; mem_ready = r;
        expq.push_back(e);
        #1 check(nm);
        @(negedge clk);
    endtask

    task automatic add(input logic [6:0] o, input logic z, input int n,
                       input logic [5:0][14:0] s, input string nm);
        vec_t v;
        v.op = o; v.z = z; v.n = n; v.seq = s; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(7'b0, 1'b0, 1'b1, V_ZERO, "reset_held");
        rst_n = 1'b1;
    endtask

    initial begin
        // seq packed with cycle 0 in the rightmost slot
        add(7'b0000011, 1'b0, 5, {V_ZERO, V_MEMWB, V_MEMRD, V_MEMADR, V_DEC, V_FETCH}, "lw");
        add(7'b0100011, 1'b0, 4, {V_ZERO, V_ZERO, V_MEMWR, V_MEMADR, V_DEC, V_FETCH}, "sw");
        add(7'b0110011, 1'b0, 4, {V_ZERO, V_ZERO, V_ALUWB, V_EXR, V_DEC, V_FETCH}, "rtype");
        add(7'b0010011, 1'b1, 4, {V_ZERO, V_ZERO, V_ALUWB, V_EXI, V_DEC, V_FETCH}, "itype");
        add(7'b1100011, 1'b1, 3, {V_ZERO, V_ZERO, V_ZERO, V_BEQ1, V_DEC, V_FETCH}, "beq_taken");
        add(7'b1100011, 1'b0, 3, {V_ZERO, V_ZERO, V_ZERO, V_BEQ0, V_DEC, V_FETCH}, "beq_not");
        add(7'b1101111, 1'b0, 4, {V_ZERO, V_ZERO, V_ALUWB, V_JAL, V_DEC, V_FETCH}, "jal");
        add(7'b0110111, 1'b0, 3, {V_ZERO, V_ZERO, V_ZERO, V_LUI, V_DEC, V_FETCH}, "lui");
`ifndef ILLEGAL_OP_TRAP_EN
        add(7'b1111111, 1'b0, 2, {V_ZERO, V_ZERO, V_ZERO, V_ZERO, V_DEC, V_FETCH}, "illegal_nop");
`endif
        add(7'b0000011, 1'b0, 5, {V_ZERO, V_MEMWB, V_MEMRD, V_MEMADR, V_DEC, V_FETCH}, "lw2");

        @(negedge clk);
        rst_n = 1'b0;
        step(7'b0, 1'b0, 1'b1, V_ZERO, "reset_out0");
        step(7'b0, 1'b0, 1'b1, V_ZERO, "reset_out1");
        rst_n = 1'b1;

        foreach (tbl[i])
            for (int c = 0; c < tbl[i].n; c++)
                step(tbl[i].op, tbl[i].z, 1'b1, tbl[i].seq[c], tbl[i].nm);

        // store held off by memory for three cycles
        step(7'b0100011, 1'b0, 1'b1, V_FETCH, "sw_wait");
        step(7'b0100011, 1'b0, 1'b1, V_DEC, "sw_wait");
        step(7'b0100011, 1'b0, 1'b1, V_MEMADR, "sw_wait");
        for (int k = 0; k < 3; k++) step(7'b0100011, 1'b0, 1'b0, V_MEMWR, "sw_wait_hold");
        step(7'b0100011, 1'b0, 1'b1, V_MEMWR, "sw_wait_done");
        step(7'b0110111, 1'b0, 1'b1, V_FETCH, "sw_wait_next");
        step(7'b0110111, 1'b0, 1'b1, V_DEC, "lui_after_sw");
        step(7'b0110111, 1'b0, 1'b1, V_LUI, "lui_after_sw");

        // ready arrives exactly when the counter reaches the limit: completes, no halt
        for (int k = 0; k < 4; k++) step(7'b0110111, 1'b0, 1'b0, V_FWAIT, "edge_wait");
        step(7'b0110111, 1'b0, 1'b1, V_FETCH, "edge_ready_at_limit");
        step(7'b0110111, 1'b0, 1'b1, V_DEC, "edge_decode");
        step(7'b0110111, 1'b0, 1'b1, V_LUI, "edge_lui");

        // counter restarts per access: 3 waits in FETCH then 4 in MEMREAD stays legal
        for (int k = 0; k < 3; k++) step(7'b0000011, 1'b0, 1'b0, V_FWAIT, "cnt_clr_fetch");
        step(7'b0000011, 1'b0, 1'b1, V_FETCH, "cnt_clr_fetch_done");
        step(7'b0000011, 1'b0, 1'b1, V_DEC, "cnt_clr");
        step(7'b0000011, 1'b0, 1'b1, V_MEMADR, "cnt_clr");
        for (int k = 0; k < 4; k++) step(7'b0000011, 1'b0, 1'b0, V_MEMRD, "cnt_clr_memrd");
        step(7'b0000011, 1'b0, 1'b1, V_MEMRD, "cnt_clr_memrd_done");
        step(7'b0000011, 1'b0, 1'b1, V_MEMWB, "cnt_clr_wb");

        // fetch never acknowledged: five request cycles, then HALT until reset
        for (int k = 0; k < 5; k++) step(7'b0110011, 1'b0, 1'b0, V_FWAIT, "timeout_wait");
        step(7'b0110011, 1'b0, 1'b1, V_HALT, "timeout_halt");
        step(7'b0110011, 1'b1, 1'b1, V_HALT, "halt_sticky");
        do_reset();
        step(7'b0110011, 1'b0, 1'b1, V_FETCH, "after_halt_fetch");
        step(7'b0110011, 1'b0, 1'b1, V_DEC, "after_halt_dec");
        step(7'b0110011, 1'b0, 1'b1, V_EXR, "after_halt_exr");
        step(7'b0110011, 1'b0, 1'b1, V_ALUWB, "after_halt_wb");

`ifdef ILLEGAL_OP_TRAP_EN
        step(7'b1111111, 1'b0, 1'b1, V_FETCH, "illegal_fetch");
        step(7'b1111111, 1'b0, 1'b1, V_DEC, "illegal_dec");
        step(7'b1111111, 1'b0, 1'b1, V_HALT, "illegal_halt");
        step(7'b1111111, 1'b0, 1'b1, V_HALT, "illegal_halt_sticky");
        do_reset();
`endif

        // asynchronous reset in the middle of a stalled load
        step(7'b0000011, 1'b0, 1'b1, V_FETCH, "rst_mid_fetch");
        step(7'b0000011, 1'b0, 1'b1, V_DEC, "rst_mid_dec");
        step(7'b0000011, 1'b0, 1'b1, V_MEMADR, "rst_mid_memadr");
        step(7'b0000011, 1'b0, 1'b0, V_MEMRD, "rst_mid_memrd");
        rst_n = 1'b0;
        expq.push_back(V_ZERO);
        #1 check("rst_mid_immediate");
        @(negedge clk);
        step(7'b0000011, 1'b0, 1'b1, V_ZERO, "rst_mid_held");
        rst_n = 1'b1;
        step(7'b0000011, 1'b0, 1'b0, V_FWAIT, "rst_release_fetch");
        step(7'b0000011, 1'b0, 1'b1, V_FETCH, "rst_release_fetch_ack");
        step(7'b0000011, 1'b0, 1'b1, V_DEC, "rst_release_dec");

        if (expq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left %0d expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
